// File: rtl/lpmul_iter.sv
// rtl/lpmul_iter.sv - iterative signed/unsigned W x W multiplier with optional saturation
module lpmul_iter #(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           sign,
  input  logic           sat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           sat_flag
);

  localparam int N  = W / STEP;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2*W-1:0] HALF    = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [2*W-1:0] FULL    = {{(W-1){1'b0}}, 1'b1, {W{1'b0}}};
  localparam logic [2*W-1:0] POS_LIM = HALF - 1'b1;
  localparam logic [2*W-1:0] NEG_LIM = ~HALF + 1'b1;
  localparam logic [2*W-1:0] U_MAX   = FULL - 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           sign_q;
  logic           sat_q;

  logic [W-1:0]   mag_a_in;
  logic [W-1:0]   mag_b_in;
  logic [2*W-1:0] slice_ext;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] neg_p;
  logic [2*W-1:0] res_n;
  logic           flag_n;

  assign in_ready = (state == IDLE);

  // The most negative operand negates onto itself, which is exactly its unsigned magnitude.
  assign mag_a_in = (sign && op_a[W-1]) ? (~op_a + 1'b1) : op_a;
  assign mag_b_in = (sign && op_b[W-1]) ? (~op_b + 1'b1) : op_b;

  assign slice_ext = {{(2*W-STEP){1'b0}}, b_sh[STEP-1:0]};
  assign acc_next  = acc + a_sh * slice_ext;
  assign neg_p     = ~acc_next + 1'b1;

  always_comb begin
    res_n  = acc_next;
    flag_n = 1'b0;
    if (!sat_q) begin
      res_n = neg_q ? neg_p : acc_next;
    end else if (sign_q && !neg_q) begin
      if (acc_next >= HALF) begin
        res_n  = POS_LIM;
        flag_n = 1'b1;
      end
    end else if (sign_q && neg_q) begin
      if (acc_next > HALF) begin
        res_n  = NEG_LIM;
        flag_n = 1'b1;
      end else begin
        res_n = neg_p;
      end
    end else if (acc_next >= FULL) begin
      res_n  = U_MAX;
      flag_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      sign_q    <= 1'b0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= {{W{1'b0}}, mag_a_in};
            b_sh   <= mag_b_in;
            acc    <= '0;
            cnt    <= '0;
            neg_q  <= sign & (op_a[W-1] ^ op_b[W-1]);
            sign_q <= sign;
            sat_q  <= sat;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_next;
          a_sh <= a_sh << STEP;
          b_sh <= b_sh >> STEP;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            res       <= res_n;
            sat_flag  <= flag_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpmul_iter.sv
// tb/tb_lpmul_iter.sv - directed bench for lpmul_iter (W=8/STEP=1 and W=16/STEP=4)
module tb_lpmul_iter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, sign, sat, out_valid, out_ready, sat_flag;
  logic [7:0]  op_a, op_b;
  logic [15:0] res;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_sat_flag;
  logic [15:0] w_op_a, w_op_b;
  logic [31:0] w_res;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lpmul_iter #(.W(8), .STEP(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sign(sign), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .sat_flag(sat_flag)
  );

  lpmul_iter #(.W(16), .STEP(4)) dut_w (
    .clk(clk), .rstn(rstn), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .op_a(w_op_a), .op_b(w_op_b), .sign(1'b0), .sat(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .res(w_res), .sat_flag(w_sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns result and cycles from acceptance edge to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        input logic st, output logic [15:0] r, output logic f,
                        output int lat);
    op_a = a; op_b = b; sign = sg; sat = st; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res;
    f = sat_flag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] r;
  logic        f;
  int          lat;
  int          rose;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    sign = 1'b0; sat = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_op_a = '0; w_op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_res", res, 0);
    check("reset_sat_flag", sat_flag, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 8'd3, 1'b0, 1'b0, r, f, lat);
    check("u200x3_res", r, 16'h0258);
    check("u200x3_flag", f, 0);
    check("u200x3_latency", lat, 8);
    check("u200x3_out_valid_fall", out_valid, 0);
    check("u200x3_in_ready_back", in_ready, 1);

    run_op(8'd200, 8'd3, 1'b0, 1'b1, r, f, lat);
    check("u200x3_sat_res", r, 16'h00FF);
    check("u200x3_sat_flag", f, 1);

    run_op(8'h80, 8'h80, 1'b1, 1'b0, r, f, lat);
    check("s_m128sq_res", r, 16'h4000);
    run_op(8'h80, 8'h80, 1'b1, 1'b1, r, f, lat);
    check("s_m128sq_sat_res", r, 16'h007F);
    check("s_m128sq_sat_flag", f, 1);

    run_op(8'hF0, 8'd8, 1'b1, 1'b1, r, f, lat);
    check("s_m16x8_res", r, 16'hFF80);
    check("s_m16x8_flag", f, 0);
    run_op(8'hEF, 8'd8, 1'b1, 1'b1, r, f, lat);
    check("s_m17x8_res", r, 16'hFF80);
    check("s_m17x8_flag", f, 1);
    run_op(8'd127, 8'd1, 1'b1, 1'b1, r, f, lat);
    check("s_127x1_res", r, 16'h007F);
    check("s_127x1_flag", f, 0);

    run_op(8'hFD, 8'd5, 1'b1, 1'b0, r, f, lat);
    check("s_m3x5_res", r, 16'hFFF1);
    run_op(8'd0, 8'hF9, 1'b1, 1'b0, r, f, lat);
    check("s_0xm7_res", r, 16'h0000);

    // Backpressure: hold the result in DONE while the producer pushes junk.
    op_a = 8'd200; op_b = 8'd3; sign = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      op_a = 8'd5; op_b = 8'd5;
      @(posedge clk); #1;
      check("bp_res_hold", res, 16'h0258);
      check("bp_flag_hold", sat_flag, 0);
      check("bp_out_valid_hold", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    op_a = 8'd11; op_b = 8'd13; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_latency", lat, 8);
    check("bp_next_res", res, 16'h008F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during BUSY cycle 4 aborts the operation.
    op_a = 8'd200; op_b = 8'd3; sign = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res", res, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rose = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose++;
    end
    check("rst_no_result", rose, 0);
    run_op(8'd7, 8'd9, 1'b0, 1'b0, r, f, lat);
    check("rst_after_7x9", r, 16'h003F);

    // Wide configuration: W=16, STEP=4.
    w_op_a = 16'hFFFF; w_op_b = 16'hFFFF; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("wide_latency", lat, 4);
    check("wide_res", w_res, 32'hFFFE0001);
    check("wide_flag", w_sat_flag, 0);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    check("wide_in_ready_back", w_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
